fifo_word_packer: RTL and testbench

- Sits directly downstream of the show-ahead (ShowHead=1) async FIFO read port, in the FIFO's read clock domain.
- Pops DataWidth-bit words from the FIFO and packs PackRatio of them into one wide beat.
- Presents each wide beat on a valid/ready output toward the wide datapath or RAM.
- Supports flushing a partially filled beat, with a per-lane keep mask.

---
 rtl/fifo_word_packer.sv | 141 ++++++++++++++
 tb/tb_fifo_word_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Packs PackRatio show-ahead FIFO words into one wide valid/ready beat, with flush of partial beats.
// Optional PACK_TIMEOUT_EN adds an idle counter that flushes a stalled partial beat.
module fifo_word_packer #(
  parameter int DataWidth = 32,
  parameter int PackRatio = 4,
  parameter int CntWidth  = 2
`ifdef PACK_TIMEOUT_EN
  , parameter int TimeoutCycles = 16
`endif
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           FifoNotEmpty,
  input  logic [DataWidth-1:0]           FifoReadData,
  output logic                           FifoRead,
  input  logic                           Flush,
  output logic [DataWidth*PackRatio-1:0] OutData,
  output logic [PackRatio-1:0]           OutKeep,
  output logic                           OutValid,
  input  logic                           OutReady,
  output logic [CntWidth-1:0]            LaneCnt,
  output logic                           DbgState
);

  // Output handshake: a beat transfers on any Clk edge where OutValid & OutReady;
  // OutData/OutKeep are held stable while OutValid is high and OutReady is low.
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [DataWidth-1:0]           acc_q [PackRatio];
  logic [CntWidth-1:0]            lane_cnt_q;
  logic                           pop;
  logic [CntWidth:0]              fill_n;
  logic                           complete;
  logic                           flush_req;
  logic                           emit;
  logic                           timeout_hit;
  logic [DataWidth*PackRatio-1:0] beat_d;
  logic [PackRatio-1:0]           keep_d;

  // Reset gates the pop so no word is consumed while the packer is held in reset.
  assign pop       = Reset & FifoNotEmpty & ((state_q == FILL) | OutReady);
  assign FifoRead  = pop;
  assign fill_n    = {1'b0, lane_cnt_q} + (CntWidth+1)'(pop);
  assign complete  = (state_q == FILL) & pop & (lane_cnt_q == CntWidth'(PackRatio - 1));
  assign flush_req = Flush | timeout_hit;
  assign emit      = (state_q == FILL) & (complete | (flush_req & (fill_n != '0)));
  assign LaneCnt   = lane_cnt_q;

`ifdef PACK_TIMEOUT_EN
  logic [15:0] idle_q;

  assign timeout_hit = (state_q == FILL) && (lane_cnt_q != '0) &&
                       (idle_q == 16'(TimeoutCycles - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idle_q <= '0;
    end else if (pop || emit || (state_q == HOLD)) begin
      idle_q <= '0;
    end else if (lane_cnt_q != '0) begin
      idle_q <= idle_q + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (emit) state_d = HOLD;
      HOLD:    if (OutReady) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output logic
  always_comb begin
    OutValid = (state_q == HOLD);
    DbgState = state_q;
  end

  // The beat being completed this cycle, including a word popped in the same cycle.
  always_comb begin
    beat_d = '0;
    keep_d = '0;
    for (int i = 0; i < PackRatio; i++) begin
      if (pop && (lane_cnt_q == CntWidth'(i))) begin
        beat_d[i*DataWidth +: DataWidth] = FifoReadData;
      end else begin
        beat_d[i*DataWidth +: DataWidth] = acc_q[i];
      end
      keep_d[i] = ((CntWidth+1)'(i) < fill_n);
    end
  end

  // Accumulator lanes are cleared on every emitted beat so unwritten lanes read as 0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < PackRatio; i++) acc_q[i] <= '0;
      lane_cnt_q <= '0;
      OutData    <= '0;
      OutKeep    <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (emit) begin
            OutData    <= beat_d;
            OutKeep    <= keep_d;
            for (int i = 0; i < PackRatio; i++) acc_q[i] <= '0;
            lane_cnt_q <= '0;
          end else if (pop) begin
            for (int i = 0; i < PackRatio; i++) begin
              if (lane_cnt_q == CntWidth'(i)) acc_q[i] <= FifoReadData;
            end
            lane_cnt_q <= lane_cnt_q + CntWidth'(1);
          end
        end
        HOLD: begin
          if (OutReady && pop) begin
            acc_q[0]   <= FifoReadData;
            lane_cnt_q <= CntWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: the FIFO and packing rules are modelled with queues and checked every cycle.
module tb_fifo_word_packer;

  localparam int DW = 32;
  localparam int PR = 4;
  localparam int CW = 2;
  localparam int BW = DW * PR;
`ifdef PACK_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          FifoNotEmpty = 1'b0;
  logic [DW-1:0] FifoReadData = '0;
  logic          FifoRead;
  logic          Flush = 1'b0;
  logic [BW-1:0] OutData;
  logic [PR-1:0] OutKeep;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [CW-1:0] LaneCnt;
  logic          DbgState;

  fifo_word_packer #(.DataWidth(DW), .PackRatio(PR), .CntWidth(CW)) dut (
    .Clk(Clk), .Reset(Reset), .FifoNotEmpty(FifoNotEmpty), .FifoReadData(FifoReadData),
    .FifoRead(FifoRead), .Flush(Flush), .OutData(OutData), .OutKeep(OutKeep),
    .OutValid(OutValid), .OutReady(OutReady), .LaneCnt(LaneCnt), .DbgState(DbgState)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Model state: FIFO contents, words popped into the current beat, pending beats.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] words_q[$];
  logic [BW-1:0] exp_q[$];
  logic [PR-1:0] keep_q[$];
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int last_pop = 0;

  task automatic model_emit();
    logic [BW-1:0] beat;
    beat = '0;
    for (int i = 0; i < words_q.size(); i++) beat = beat | (BW'(words_q[i]) << (i * DW));
    exp_q.push_back(beat);
    keep_q.push_back(PR'((1 << words_q.size()) - 1));
    words_q.delete();
  endtask

  // One clock cycle: called at a negedge, drives inputs, checks outputs, advances the model.
  task automatic step(input logic flush, input logic ready);
    logic exp_rd;
    logic hold;
    logic timeout;
    Flush = flush;
    OutReady = ready;
    FifoNotEmpty = (fifo_q.size() > 0);
    FifoReadData = (fifo_q.size() > 0) ? fifo_q[0] : DW'($urandom);
    #1;
    hold = (exp_q.size() > 0);
    exp_rd = (fifo_q.size() > 0) && (!hold || ready);
    checks++;
    if (FifoRead !== exp_rd) begin
      errors++; $display("FAIL fifo_read t=%0t got %b want %b", $time, FifoRead, exp_rd);
    end
    checks++;
    if (OutValid !== hold) begin
      errors++; $display("FAIL out_valid t=%0t got %b want %b", $time, OutValid, hold);
    end
    checks++;
    if (LaneCnt !== CW'(words_q.size())) begin
      errors++; $display("FAIL lane_cnt t=%0t got %0d want %0d", $time, LaneCnt, words_q.size());
    end
    if (hold) begin
      checks++;
      if (OutData !== exp_q[0]) begin
        errors++; $display("FAIL out_data t=%0t got %h want %h", $time, OutData, exp_q[0]);
      end
      checks++;
      if (OutKeep !== keep_q[0]) begin
        errors++; $display("FAIL out_keep t=%0t got %b want %b", $time, OutKeep, keep_q[0]);
      end
    end
    @(posedge Clk);
    edge_n++;
    if (!hold) begin
      timeout = 1'b0;
`ifdef PACK_TIMEOUT_EN
      if (words_q.size() > 0 && (edge_n - last_pop) >= TO) timeout = 1'b1;
`endif
      if (exp_rd) words_q.push_back(fifo_q[0]);
      if (words_q.size() == PR || ((flush || timeout) && words_q.size() > 0)) model_emit();
    end else if (ready) begin
      void'(exp_q.pop_front());
      void'(keep_q.pop_front());
      if (exp_rd) words_q.push_back(fifo_q[0]);
    end
    if (exp_rd) begin
      void'(fifo_q.pop_front());
      last_pop = edge_n;
    end
    @(negedge Clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (fifo_q.size() > 0 || exp_q.size() > 0 || words_q.size() > 0); i++)
      step(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (OutValid !== 1'b0 || OutKeep !== '0 || LaneCnt !== '0 || OutData !== '0) begin
      errors++; $display("FAIL reset_state got v=%b k=%b c=%0d d=%h want all 0", OutValid, OutKeep, LaneCnt, OutData);
    end
    FifoNotEmpty = 1'b1;
    OutReady = 1'b1;
    #1;
    checks++;
    if (FifoRead !== 1'b0) begin
      errors++; $display("FAIL reset_read got %b want 0", FifoRead);
    end
    FifoNotEmpty = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 12; k++) fifo_q.push_back(DW'(k * 32'h11));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    #1;
    checks++;
    if (OutData !== 128'h00000044_00000033_00000022_00000011 || OutKeep !== 4'b1111) begin
      errors++; $display("FAIL stream_beat0 got %h/%b want 00000044000000330000002200000011/1111", OutData, OutKeep);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] held;
    for (int k = 0; k < 6; k++) fifo_q.push_back(DW'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    held = exp_q.size() > 0 ? exp_q[0] : '0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (OutData !== held) begin
        errors++; $display("FAIL bp_stable got %h want %h", OutData, held);
      end
    end
    step(1'b0, 1'b1);
    checks++;
    if (LaneCnt !== 2'd1 || OutValid !== 1'b0) begin
      errors++; $display("FAIL bp_release got cnt=%0d v=%b want cnt=1 v=0", LaneCnt, OutValid);
    end
    drain();
  endtask

  task automatic test_partial_flush();
    fifo_q.push_back(32'hA1);
    fifo_q.push_back(32'hA2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    checks++;
    if (OutKeep !== 4'b0011 || OutData !== 128'h000000A2_000000A1) begin
      errors++; $display("FAIL partial_flush got %h/%b want a2a1/0011", OutData, OutKeep);
    end
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (OutValid !== 1'b0) begin
      errors++; $display("FAIL empty_flush got %b want 0", OutValid);
    end
  endtask

  task automatic test_flush_with_pop();
    fifo_q.push_back(32'hB1);
    fifo_q.push_back(32'hB2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    fifo_q.push_back(32'hB3);
    step(1'b1, 1'b0);
    checks++;
    if (OutKeep !== 4'b0111 || OutData[95:64] !== 32'hB3) begin
      errors++; $display("FAIL flush_pop got keep=%b lane2=%h want 0111/b3", OutKeep, OutData[95:64]);
    end
    drain();
  endtask

  task automatic test_reset_mid_beat();
    for (int k = 0; k < 6; k++) fifo_q.push_back(DW'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    FifoNotEmpty = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (OutValid !== 1'b0 || OutKeep !== '0 || LaneCnt !== '0 || FifoRead !== 1'b0) begin
      errors++; $display("FAIL reset_mid got v=%b k=%b c=%0d rd=%b want 0", OutValid, OutKeep, LaneCnt, FifoRead);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (FifoRead !== 1'b0 || LaneCnt !== '0) begin
      errors++; $display("FAIL reset_hold got rd=%b c=%0d want 0", FifoRead, LaneCnt);
    end
    @(negedge Clk);
    Reset = 1'b1;
    words_q.delete();
    exp_q.delete();
    keep_q.delete();
    drain();
  endtask

`ifdef PACK_TIMEOUT_EN
  task automatic test_timeout();
    fifo_q.push_back(32'hC1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    #1;
    checks++;
    if (OutValid !== 1'b0) begin
      errors++; $display("FAIL timeout_early got %b want 0", OutValid);
    end
    step(1'b0, 1'b0);
    #1;
    checks++;
    if (OutValid !== 1'b1 || OutKeep !== 4'b0001) begin
      errors++; $display("FAIL timeout_beat got v=%b k=%b want 1/0001", OutValid, OutKeep);
    end
    drain();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 60) fifo_q.push_back(DW'($urandom));
      step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 70);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_partial_flush();
    test_flush_with_pop();
    test_reset_mid_beat();
`ifdef PACK_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
